icache_nway: RTL
================

Name: icache_nway

Overview:
Parametrised successor to the 2-set direct-mapped instruction cache, sitting between IFU fetch (valid/ready) and the AXI4 read master of the memory bus. It supports configurable set count, line size and 1- or 2-way associativity with per-set LRU replacement. A parametrised uncached bypass window is served by single-beat reads. New relative to its predecessor: AXI read error propagation, and fence.i handling that is deferred while a request is in flight.

Parameters:
NUM_SETS, 4, number of sets; power of 2, at least 2.
NUM_WAYS, 2, associativity; legal values 1 or 2.
LINE_WORDS, 4, 32-bit words per line; power of 2, 2..16; sets AXI burst length.
BYPASS_BASE, 32'h0f00_0000, base address of the uncached window.
BYPASS_MASK, 32'hff00_0000, bypass when (addr & MASK) == BASE.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fence_i_i  in  1  level request to invalidate all lines
icache_flush_done  out  1  one-cycle pulse when invalidation is complete
cpu_arvalid_i  in  1  fetch request valid
cpu_arready_o  out  1  fetch request accept
cpu_araddr_i  in  32  fetch address; bits [1:0] ignored
cpu_rvalid_o  out  1  fetch data valid
cpu_rready_i  in  1  fetch data accept
cpu_rdata_o  out  32  instruction word
cpu_rerr_o  out  1  AXI error on this fetch; qualified by rvalid
axi_arvalid_o  out  1  AR valid
axi_arready_i  in  1  AR ready
axi_araddr_o  out  32  AR address
axi_arlen_o  out  8  burst length minus 1
axi_rvalid_i  in  1  R valid
axi_rready_o  out  1  R ready
axi_rdata_i  in  32  R data
axi_rresp_i  in  2  R response; bit 1 set means error
axi_rlast_i  in  1  R last beat

Behaviour:
- Address split: OFFSET = log2(LINE_WORDS*4); INDEX = log2(NUM_SETS); TAG = the remaining upper bits.
- Reset (synchronous, rst high at posedge):
  - state = IDLE.
  - All valid bits and LRU bits = 0.
  - All outputs = 0, except cpu_arready_o, which goes high combinationally in IDLE when fence_i_i is low.
  - Data and tag arrays are not reset.
- State machine: IDLE, LOOKUP, MISS_AR, MISS_R, RESP, FLUSH.
- IDLE:
  - cpu_arready_o = ~fence_i_i.
  - On handshake: latch address and bypass flag, then go to LOOKUP.
  - If fence_i_i is high: go to FLUSH.
- LOOKUP (1 cycle):
  - Bypass goes to MISS_AR.
  - Otherwise compare the tags of all ways in the indexed set.
  - Hit: set LRU to the other way (2-way only), latch the word, go to RESP. Hit latency is 2 cycles from AR handshake to rvalid.
  - Miss: victim = invalid way if any, with way0 preferred; else the LRU way. Go to MISS_AR.
- MISS_AR:
  - axi_arvalid_o is held high, with address and length stable, until axi_arready_i.
  - Fill: address = line base, arlen = LINE_WORDS-1.
  - Bypass: address = word address, arlen = 0.
  - Then go to MISS_R.
- MISS_R:
  - axi_rready_o = 1.
  - Fill: each beat is written to word beat_cnt of the victim line; the requested word is captured when beat_cnt == word_sel.
  - Fill completes on the beat with rlast. Bypass completes on its first beat, and rlast is ignored.
  - Any beat with rresp[1] set raises a sticky error.
  - On completion without error: victim tag and valid are written, LRU points away from the victim. Go to RESP.
  - On completion with error: valid for the victim = 0 and LRU is unchanged. Go to RESP with cpu_rerr_o = 1.
  - Beats after rlast never occur; the counter wraps modulo LINE_WORDS.
- RESP:
  - cpu_rvalid_o = 1, with rdata and rerr held stable.
  - On cpu_rready_i: go to IDLE. rready may arrive in the same cycle rvalid rises.
- Fence:
  - It is only acted on in IDLE, so an in-flight request completes first and a fill is never aborted.
  - FLUSH is 1 cycle: all valid and LRU bits are cleared, icache_flush_done pulses for exactly that cycle, then the block returns to IDLE.
  - If fence_i_i is still high on the return to IDLE, it does not re-flush; a re-flush requires fence_i_i to go low and then high again (rising edge tracked by a registered copy).
  - A fence and a CPU request in the same IDLE cycle: the fence wins, and arready is low.
- Width rules: beat_cnt is log2(LINE_WORDS) bits. When NUM_WAYS == 1 the LRU state is unused and the victim is always way 0.

Decomposition:
- Package icache_pkg holds:
  - The state enum.
  - Localparam functions for OFFSET/INDEX/TAG widths.
  - The rresp error decode constant.
- One sub-module, icache_tag_way, is natural: tag and valid array plus compare for one way, instantiated NUM_WAYS times.
- The data arrays stay in the top level.

Test Plan:
- Cold miss then hit (defaults): fetch 0x8000_0008.
  - AR addr 0x8000_0000, arlen 3.
  - Four beats A0..A3 return; rdata = A2.
  - Re-fetch 0x8000_0004: no AR, rdata = A1, 2-cycle latency.
- 2-way LRU: fill 0x8000_0000 then 0x8000_0040 (same set, both valid).
  - Touch 0x8000_0000, then fetch 0x8000_0080.
  - The 0x...40 line is evicted; 0x8000_0000 still hits.
- Bypass: fetch 0x0f00_1234.
  - AR addr 0x0f00_1234, arlen 0, rlast held 0; data is returned anyway.
  - Re-fetch misses again with a new AR.
- Error: fill with rresp=2'b10 on beat 1.
  - cpu_rerr_o = 1.
  - The same address refetches via AR, i.e. the line stays invalid.
- Fence during a fill: assert fence_i_i during MISS_R.
  - The fill completes and RESP is delivered.
  - Then a FLUSH pulse occurs, and the next fetch of that line misses.
- Reset mid-burst: assert rst during MISS_R.
  - Next cycle: state IDLE, arvalid=0, rready=0, all lines invalid.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the N-way instruction cache.
//   state_e        - controller states
//   offset_w()     - byte-offset width of an address for a given line size
//   index_w()      - set-index width for a given set count
//   tag_w()        - remaining tag width of a 32-bit address
//   RRESP_ERR_BIT  - rresp bit that flags SLVERR/DECERR
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MISS_AR = 3'd2,
    ST_MISS_R  = 3'd3,
    ST_RESP    = 3'd4,
    ST_FLUSH   = 3'd5
  } state_e;

  localparam int unsigned RRESP_ERR_BIT = 1;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned num_sets,
                                        input int unsigned line_words);
    return 32 - offset_w(line_words) - index_w(num_sets);
  endfunction

endpackage

// File: rtl/icache_tag_way.sv
// icache_tag_way: tag + valid storage and tag compare for one cache way.
//   clk, rst    - clock, synchronous active-high reset (clears valid bits)
//   flush_i     - clear every valid bit of this way
//   idx_i       - set index used for both lookup and write
//   tag_i       - tag to compare against / tag to store
//   wr_en_i     - write tag_i and wr_valid_i into set idx_i
//   wr_valid_i  - valid value written with the tag
//   hit_o       - indexed set is valid and its tag matches tag_i
//   valid_o     - valid bit of the indexed set
module icache_tag_way
  import icache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned TAG_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             wr_en_i,
  input  logic             wr_valid_i,
  output logic             hit_o,
  output logic             valid_o
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] valid_d;
  logic [TAG_W-1:0]    tag_mem [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign hit_o   = valid_q[idx_i] && (tag_mem[idx_i] == tag_i);

  // Next valid vector: flush clears everything, a completed fill sets/clears one entry.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[idx_i] = wr_valid_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag storage; intentionally not reset, valid bits qualify it.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_mem[idx_i] <= tag_i;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: 1- or 2-way set-associative instruction cache between the IFU
// fetch port and an AXI4 read master, with an uncached bypass window, AXI
// read-error propagation and deferred fence.i invalidation.
//   clk, rst                      - clock, synchronous active-high reset
//   fence_i_i / icache_flush_done - invalidate request / one-cycle completion pulse
//   cpu_ar*                       - fetch request (word address, bits [1:0] ignored)
//   cpu_r*                        - fetch response (data, error flag)
//   axi_ar* / axi_r*              - AXI4 read address / read data channels
module icache_nway
  import icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned NUM_WAYS    = 2,
  parameter int unsigned LINE_WORDS  = 4,
  parameter logic [31:0] BYPASS_BASE = 32'h0f00_0000,
  parameter logic [31:0] BYPASS_MASK = 32'hff00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fence_i_i,
  output logic        icache_flush_done,
  input  logic        cpu_arvalid_i,
  output logic        cpu_arready_o,
  input  logic [31:0] cpu_araddr_i,
  output logic        cpu_rvalid_o,
  input  logic        cpu_rready_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_rerr_o,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  output logic [31:0] axi_araddr_o,
  output logic [7:0]  axi_arlen_o,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rlast_i
);

  localparam int unsigned OFF_W  = offset_w(LINE_WORDS);
  localparam int unsigned IDX_W  = index_w(NUM_SETS);
  localparam int unsigned TAG_W  = tag_w(NUM_SETS, LINE_WORDS);
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

  state_e              state_q,      state_d;
  logic [31:2]         addr_q,       addr_d;
  logic                bypass_q,     bypass_d;
  logic                victim_q,     victim_d;
  logic [BEAT_W-1:0]   beat_q,       beat_d;
  logic                err_q,        err_d;
  logic [31:0]         rdata_q,      rdata_d;
  logic                rerr_q,       rerr_d;
  logic                fence_seen_q, fence_seen_d;
  logic [NUM_SETS-1:0] lru_q,        lru_d;

  logic [31:0] data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];

  logic [IDX_W-1:0]    idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic [BEAT_W-1:0]   word_s;
  logic [NUM_WAYS-1:0] way_hit_s;
  logic [NUM_WAYS-1:0] way_valid_s;
  logic                hit_s;
  logic                hit_way_s;
  logic                victim_s;
  logic                beat_fire_s;
  logic                fill_done_s;
  logic                err_final_s;
  logic                tag_wr_s;
  logic                data_wr_s;
  logic                flush_s;
  logic                bits_unused_s;

  // Byte-lane bits and the non-error rresp bit carry no information here.
  assign bits_unused_s = ^{cpu_araddr_i[1:0], axi_rresp_i[0]};

  assign idx_s  = addr_q[OFF_W +: IDX_W];
  assign tag_s  = addr_q[31 -: TAG_W];
  assign word_s = addr_q[2 +: BEAT_W];

  assign hit_s     = |way_hit_s;
  assign hit_way_s = (NUM_WAYS == 2) ? way_hit_s[NUM_WAYS-1] : 1'b0;

  assign beat_fire_s = (state_q == ST_MISS_R) && axi_rvalid_i;
  // A bypass read is a single beat, so its rlast is deliberately ignored.
  assign fill_done_s = beat_fire_s && (bypass_q || axi_rlast_i);
  assign err_final_s = err_q || axi_rresp_i[RRESP_ERR_BIT];
  assign tag_wr_s    = fill_done_s && !bypass_q;
  assign data_wr_s   = beat_fire_s && !bypass_q;
  assign flush_s     = (state_q == ST_FLUSH);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    localparam logic WAY_ID = 1'(w);
    icache_tag_way #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W)
    ) u_tag (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_s),
      .idx_i      (idx_s),
      .tag_i      (tag_s),
      .wr_en_i    (tag_wr_s && (victim_q == WAY_ID)),
      .wr_valid_i (!err_final_s),
      .hit_o      (way_hit_s[w]),
      .valid_o    (way_valid_s[w])
    );
  end

  // Victim choice: first invalid way (way 0 first), otherwise the LRU way.
  always_comb begin
    victim_s = 1'b0;
    if (NUM_WAYS == 2) begin
      if (!way_valid_s[0]) begin
        victim_s = 1'b0;
      end else if (!way_valid_s[NUM_WAYS-1]) begin
        victim_s = 1'b1;
      end else begin
        victim_s = lru_q[idx_s];
      end
    end else begin
      victim_s = 1'b0;
    end
  end

  // Controller next-state and datapath latching.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bypass_d = bypass_q;
    victim_d = victim_q;
    beat_d   = beat_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    case (state_q)
      ST_IDLE: begin
        // A serviced fence must drop before it can trigger another flush.
        if (fence_i_i && !fence_seen_q) begin
          state_d = ST_FLUSH;
        end else if (cpu_arvalid_i && !fence_i_i) begin
          addr_d   = cpu_araddr_i[31:2];
          bypass_d = ((cpu_araddr_i & BYPASS_MASK) == BYPASS_BASE);
          state_d  = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (bypass_q) begin
          state_d = ST_MISS_AR;
        end else if (hit_s) begin
          rdata_d = data_mem[hit_way_s][idx_s][word_s];
          rerr_d  = 1'b0;
          state_d = ST_RESP;
        end else begin
          victim_d = victim_s;
          state_d  = ST_MISS_AR;
        end
      end
      ST_MISS_AR: begin
        if (axi_arready_i) begin
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = ST_MISS_R;
        end else begin
          state_d = ST_MISS_AR;
        end
      end
      ST_MISS_R: begin
        if (beat_fire_s) begin
          beat_d = beat_q + BEAT_W'(1);
          err_d  = err_final_s;
          if (bypass_q || (beat_q == word_s)) begin
            rdata_d = axi_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
          if (fill_done_s) begin
            rerr_d  = err_final_s;
            state_d = ST_RESP;
          end else begin
            state_d = ST_MISS_R;
          end
        end else begin
          state_d = ST_MISS_R;
        end
      end
      ST_RESP: begin
        if (cpu_rready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fence edge tracking: remember a serviced fence until the request drops.
  always_comb begin
    fence_seen_d = fence_seen_q;
    if (state_q == ST_FLUSH) begin
      fence_seen_d = 1'b1;
    end else if (!fence_i_i) begin
      fence_seen_d = 1'b0;
    end else begin
      fence_seen_d = fence_seen_q;
    end
  end

  // LRU bit per set names the way to evict next.
  always_comb begin
    lru_d = lru_q;
    if (flush_s) begin
      lru_d = '0;
    end else if ((state_q == ST_LOOKUP) && !bypass_q && hit_s) begin
      lru_d[idx_s] = ~hit_way_s;
    end else if (tag_wr_s && !err_final_s) begin
      lru_d[idx_s] = ~victim_q;
    end else begin
      lru_d = lru_q;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 30'h0;
      bypass_q     <= 1'b0;
      victim_q     <= 1'b0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
      rerr_q       <= 1'b0;
      fence_seen_q <= 1'b0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bypass_q     <= bypass_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
      fence_seen_q <= fence_seen_d;
      lru_q        <= lru_d;
    end
  end

  // Line data storage; every beat of a fill lands in the victim way.
  always_ff @(posedge clk) begin
    if (data_wr_s) begin
      data_mem[victim_q][idx_s][beat_q] <= axi_rdata_i;
    end
  end

  assign cpu_arready_o     = (state_q == ST_IDLE) && !fence_i_i;
  assign cpu_rvalid_o      = (state_q == ST_RESP);
  assign cpu_rdata_o       = rdata_q;
  assign cpu_rerr_o        = rerr_q;
  assign icache_flush_done = flush_s;
  assign axi_arvalid_o     = (state_q == ST_MISS_AR);
  assign axi_rready_o      = (state_q == ST_MISS_R);
  assign axi_araddr_o      = (state_q != ST_MISS_AR) ? 32'h0 :
                             bypass_q ? {addr_q, 2'b00} :
                             {addr_q[31:OFF_W], OFF_W'(0)};
  assign axi_arlen_o       = ((state_q == ST_MISS_AR) && !bypass_q) ?
                             8'(LINE_WORDS - 1) : 8'h00;

endmodule
